// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response port of the fetch unit.
// Handshake: a request transfers on a cycle where ImemReq && ImemReady; one response
// (ImemRValid, ImemRData) follows later, and at most one request is ever outstanding.
interface fetch_unit_if;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemReady;
    logic        ImemRValid;
    logic [31:0] ImemRData;

    modport master (
        output ImemReq,
        output ImemAddr,
        input  ImemReady,
        input  ImemRValid,
        input  ImemRData
    );

    modport slave (
        input  ImemReq,
        input  ImemAddr,
        output ImemReady,
        output ImemRValid,
        output ImemRData
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, single-outstanding imem request FSM and
// the IF/ID pipeline register, honouring stall, flush and Execute-stage redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               StallF,
    input  logic               StallD,
    input  logic               FlushD,
    input  logic               PCSrcE,
    input  logic [31:0]        PCTargetE,
    fetch_unit_if.master       imem,
    output logic [31:0]        InstrD,
    output logic [31:0]        PCD,
    output logic [31:0]        PCPlus4D,
    output logic               ValidD,
    output logic               FetchBusy,
    output logic [1:0]         dbg_state_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic        drop_q, drop_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;

    logic [31:0] ifid_instr_q, ifid_pc_q, ifid_pc4_q;
    logic        ifid_valid_q;

    logic        deliver;
    logic [31:0] deliver_instr;
    logic [31:0] deliver_pc;
    logic        go;

    assign go = !StallF && !StallD;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_REQ;
            pcf_q        <= RESET_PC;
            drop_q       <= 1'b0;
            hold_instr_q <= NOP_INSTR;
            hold_pc_q    <= RESET_PC;
        end else begin
            state_q      <= state_d;
            pcf_q        <= pcf_d;
            drop_q       <= drop_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    // Next-state logic; a redirect always wins over stall and delivery
    always_comb begin
        state_d       = state_q;
        pcf_d         = pcf_q;
        drop_d        = drop_q;
        hold_instr_d  = hold_instr_q;
        hold_pc_d     = hold_pc_q;
        deliver       = 1'b0;
        deliver_instr = imem.ImemRData;
        deliver_pc    = pcf_q;
        case (state_q)
            S_REQ: begin
                if (PCSrcE) begin
                    pcf_d = PCTargetE;
                    if (imem.ImemReady) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end
                end else if (imem.ImemReady) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (PCSrcE) begin
                    pcf_d = PCTargetE;
                    if (imem.ImemRValid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem.ImemRValid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (go) begin
                        deliver = 1'b1;
                        pcf_d   = pcf_q + 32'd4;
                        state_d = S_REQ;
                    end else begin
                        hold_instr_d = imem.ImemRData;
                        hold_pc_d    = pcf_q;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                deliver_instr = hold_instr_q;
                deliver_pc    = hold_pc_q;
                if (PCSrcE) begin
                    pcf_d   = PCTargetE;
                    state_d = S_REQ;
                end else if (go) begin
                    deliver = 1'b1;
                    pcf_d   = hold_pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
                drop_d  = 1'b0;
            end
        endcase
    end

    // Output logic: request and address come from registered state only
    always_comb begin
        imem.ImemReq  = (state_q == S_REQ) && !reset;
        imem.ImemAddr = pcf_q;
        FetchBusy     = (state_q == S_REQ) || (state_q == S_WAIT);
        dbg_state_o   = state_q;
    end

    // IF/ID: a bubble goes in whenever Decode is not stalled and nothing was delivered
    always_ff @(posedge clk) begin
        if (reset || FlushD) begin
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= 32'd0;
            ifid_pc4_q   <= 32'd0;
            ifid_valid_q <= 1'b0;
        end else if (!StallD) begin
            if (deliver) begin
                ifid_instr_q <= deliver_instr;
                ifid_pc_q    <= deliver_pc;
                ifid_pc4_q   <= deliver_pc + 32'd4;
                ifid_valid_q <= 1'b1;
            end else begin
                ifid_instr_q <= NOP_INSTR;
                ifid_pc_q    <= 32'd0;
                ifid_pc4_q   <= 32'd0;
                ifid_valid_q <= 1'b0;
            end
        end
    end

    assign InstrD   = ifid_instr_q;
    assign PCD      = ifid_pc_q;
    assign PCPlus4D = ifid_pc4_q;
    assign ValidD   = ifid_valid_q;

endmodule
